// File: rtl/hcmpp_bram_pkg.sv
// Shared constants, row type and pack/unpack helpers for the hit-count-map RAM.
package hcmpp_pkg;

    localparam int ADDR_WIDTH   = 10;
    localparam int DATA_WIDTH   = 11;
    localparam int READ_LATENCY = 2;
    localparam int MAXHITNBITS  = 3;
    localparam int HIM_WIDTH    = DATA_WIDTH - MAXHITNBITS;
    localparam int DEPTH        = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] hcm_row_t;
    typedef logic [ADDR_WIDTH-1:0] hcm_addr_t;

    function automatic hcm_row_t pack_row(input logic [MAXHITNBITS-1:0] nhits,
                                          input logic [HIM_WIDTH-1:0] him_addr);
        return {him_addr, nhits};
    endfunction

    function automatic logic [MAXHITNBITS-1:0] row_nhits(input hcm_row_t row);
        return row[MAXHITNBITS-1:0];
    endfunction

    function automatic logic [HIM_WIDTH-1:0] row_him(input hcm_row_t row);
        return row[DATA_WIDTH-1:MAXHITNBITS];
    endfunction

endpackage

// File: rtl/hcmpp_bram_if.sv
// Dual-port access bundle for the HCM RAM: port A (update) and port B (read).
interface hcmpp_bram_if;
    import hcmpp_pkg::*;

    logic      ena;
    logic      wea;
    hcm_addr_t addra;
    hcm_row_t  dina;
    hcm_row_t  douta;
    logic      enb;
    logic      web;
    hcm_addr_t addrb;
    hcm_row_t  dinb;
    hcm_row_t  doutb;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  douta, doutb
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output douta, doutb
    );

endinterface

// File: rtl/hcmpp_bram_pipe.sv
// Read-data delay line: stage 0 loads only when enabled, later stages shift every cycle.
module hcmpp_bram_pipe #(
    parameter int WIDTH   = 11,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] tap [LATENCY];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset)
                        q_reg <= '0;
                    else if (en)
                        q_reg <= din;
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (reset)
                        q_reg <= '0;
                    else
                        q_reg <= tap[gi-1];
                end
            end
            assign tap[gi] = q_reg;
        end
    endgenerate

    assign dout = tap[LATENCY-1];

endmodule

// File: rtl/hcmpp_bram.sv
// True dual-port HCM RAM. Define HCMPP_BRAM_BYPASS_EN to forward new data on
// cross-port write/read collisions; otherwise every collision is read-first.
module hcmpp_bram
    import hcmpp_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hcmpp_bram_if.slave  bus
);

    hcm_row_t mem [DEPTH] = '{default: '0};

    logic     a_wr;
    logic     b_wr;
    logic     same_addr;
    hcm_row_t rd_a;
    hcm_row_t rd_b;

    assign same_addr = (bus.addra == bus.addrb);
    assign a_wr      = bus.ena & bus.wea;
    // A wins a write/write collision, so B's write is dropped rather than ordered.
    assign b_wr      = bus.enb & bus.web & ~(a_wr & same_addr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (a_wr)
                mem[bus.addra] <= bus.dina;
            if (b_wr)
                mem[bus.addrb] <= bus.dinb;
        end
    end

`ifdef HCMPP_BRAM_BYPASS_EN
    assign rd_a = (b_wr & same_addr) ? bus.dinb : mem[bus.addra];
    assign rd_b = (a_wr & same_addr) ? bus.dina : mem[bus.addrb];
`else
    assign rd_a = mem[bus.addra];
    assign rd_b = mem[bus.addrb];
`endif

    hcmpp_bram_pipe #(
        .WIDTH   (DATA_WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_pipe_a (
        .clk   (clk),
        .reset (reset),
        .en    (bus.ena),
        .din   (rd_a),
        .dout  (bus.douta)
    );

    hcmpp_bram_pipe #(
        .WIDTH   (DATA_WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_pipe_b (
        .clk   (clk),
        .reset (reset),
        .en    (bus.enb),
        .din   (rd_b),
        .dout  (bus.doutb)
    );

endmodule

// File: tb/tb_hcmpp_bram.sv
// Directed bench for hcmpp_bram: latency, collisions, reset behaviour, enable hold, edges.
module tb_hcmpp_bram;
    import hcmpp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;
    hcm_row_t exp_seq [4];

    hcmpp_bram_if bus ();

    hcmpp_bram dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input hcm_row_t obs, input hcm_row_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, expv);
        end
        $display("check %-16s observed 0x%03h expected 0x%03h", tag, obs, expv);
    endtask

    task automatic idle();
        bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
        bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = '0; bus.dinb = '0;
    endtask

    task automatic write_a(input hcm_addr_t addr, input hcm_row_t data);
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = addr; bus.dina = data;
        tick();
        idle();
    endtask

    task automatic read_a(input string tag, input hcm_addr_t addr, input hcm_row_t expv);
        bus.ena = 1'b1; bus.addra = addr;
        tick();
        idle();
        repeat (READ_LATENCY - 1) tick();
        check(tag, bus.douta, expv);
    endtask

    task automatic read_b(input string tag, input hcm_addr_t addr, input hcm_row_t expv);
        bus.enb = 1'b1; bus.addrb = addr;
        tick();
        idle();
        repeat (READ_LATENCY - 1) tick();
        check(tag, bus.doutb, expv);
    endtask

    initial begin
        hcm_row_t coll_b;
        hcm_row_t coll_a;
`ifdef HCMPP_BRAM_BYPASS_EN
        coll_b = 11'h019;
        coll_a = 11'h055;
`else
        coll_b = 11'h000;
        coll_a = 11'h000;
`endif
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_douta", bus.douta, 11'h000);
        check("rst_doutb", bus.doutb, 11'h000);

        // 1: write on A, read on B
        write_a(10'd5, 11'h00B);
        read_b("wr_rd_5", 10'd5, 11'h00B);

        // 2: A writes while B reads the same row
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 10'd7; bus.dina = 11'h019;
        bus.enb = 1'b1; bus.addrb = 10'd7;
        tick();
        idle();
        repeat (READ_LATENCY - 1) tick();
        check("coll_ab_rd", bus.doutb, coll_b);
        read_b("coll_ab_mem", 10'd7, 11'h019);

        // 2b: B writes while A reads the same row
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 10'd9; bus.dinb = 11'h055;
        bus.ena = 1'b1; bus.addra = 10'd9;
        tick();
        idle();
        repeat (READ_LATENCY - 1) tick();
        check("coll_ba_rd", bus.douta, coll_a);
        read_a("coll_ba_mem", 10'd9, 11'h055);

        // 3: both ports write one row, A wins
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 10'd3; bus.dina = 11'h011;
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 10'd3; bus.dinb = 11'h022;
        tick();
        idle();
        read_a("ww_rd_a", 10'd3, 11'h011);
        read_b("ww_rd_b", 10'd3, 11'h011);

        // 4: reset clears outputs, not the array, and blocks writes
        read_a("pre_rst_a", 10'd5, 11'h00B);
        read_b("pre_rst_b", 10'd5, 11'h00B);
        reset = 1'b1;
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 10'd20; bus.dina = 11'h3AA;
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 10'd21; bus.dinb = 11'h155;
        tick();
        reset = 1'b0;
        idle();
        check("post_rst_a", bus.douta, 11'h000);
        check("post_rst_b", bus.doutb, 11'h000);
        read_b("reread_5", 10'd5, 11'h00B);
        read_a("rst_wr_a", 10'd20, 11'h000);
        read_b("rst_wr_b", 10'd21, 11'h000);

        // 6: top row and row 0
        write_a(10'd1023, 11'h7FF);
        read_b("top_row", 10'd1023, 11'h7FF);
        read_a("row0_zero", 10'd0, 11'h000);

        // 5: enable low holds output
        read_b("hold_src", 10'd5, 11'h00B);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_%0d", i), bus.doutb, 11'h00B);
        end

        // 5b: back-to-back reads of rows 0..3
        write_a(10'd0, 11'h101);
        write_a(10'd1, 11'h202);
        write_a(10'd2, 11'h303);
        exp_seq[0] = 11'h101;
        exp_seq[1] = 11'h202;
        exp_seq[2] = 11'h303;
        exp_seq[3] = 11'h011;
        for (int t = 0; t < 4 + READ_LATENCY - 1; t++) begin
            bus.enb   = (t < 4);
            bus.addrb = hcm_addr_t'(t);
            tick();
            if (t >= READ_LATENCY - 1)
                check($sformatf("b2b_%0d", t - READ_LATENCY + 1), bus.doutb,
                      exp_seq[t - READ_LATENCY + 1]);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
